// File: rtl/ip_pipe.sv
// Integer execution pipe: ALU evaluated at issue, result carried through STAGES
// registered stages to writeback with valid/ready backpressure and bubble collapsing.
module ip_pipe #(
  parameter int STAGES = 2,
  parameter int DST_W  = 5,
  parameter int PC_W   = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [PC_W-1:0]                 ix_ip_pc,
  input  logic [DST_W-1:0]                ix_ip_dst,
  input  logic                            ix_ip_wb_en,
  input  logic [2:0]                      ix_ip_op,
  input  logic                            ix_ip_option,
  input  logic                            ix_ip_truncate,
  input  logic [63:0]                     ix_ip_operand1,
  input  logic [63:0]                     ix_ip_operand2,
  input  logic                            ix_ip_valid,
  output logic                            ix_ip_ready,
  input  logic                            ip_flush,
  output logic [DST_W-1:0]                ip_ix_dst,
  output logic [63:0]                     ip_ix_result,
  output logic [PC_W-1:0]                 ip_ix_pc,
  output logic                            ip_ix_wb_en,
  output logic                            ip_ix_valid,
  input  logic                            ip_ix_ready,
  output logic [$clog2(STAGES+1)-1:0]     ip_inflight,
  output logic                            ip_busy
);

  localparam int CNT_W = $clog2(STAGES + 1);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,  // option selects SUB
    OP_SLL  = 3'b001,
    OP_SLT  = 3'b010,
    OP_SLTU = 3'b011,
    OP_XOR  = 3'b100,
    OP_SRL  = 3'b101,  // option selects SRA
    OP_OR   = 3'b110,
    OP_AND  = 3'b111
  } alu_op_e;

  logic [63:0]        alu_raw;
  logic [63:0]        alu_out;
  logic signed [63:0] sra_res;
  logic [5:0]         shamt;

  logic [STAGES-1:0]  valid_q;
  logic [STAGES-1:0]  valid_nxt;
  logic [STAGES-1:0]  adv;
  logic [STAGES-1:0]  wb_q;
  logic [DST_W-1:0]   dst_q [STAGES];
  logic [63:0]        res_q [STAGES];
  logic [PC_W-1:0]    pc_q  [STAGES];
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_nxt;

  assign shamt   = ix_ip_operand2[5:0];
  assign sra_res = $signed(ix_ip_operand1) >>> shamt;

  always_comb begin
    alu_raw = '0;
    unique case (alu_op_e'(ix_ip_op))
      OP_ADD:  alu_raw = ix_ip_option ? ix_ip_operand1 - ix_ip_operand2
                                      : ix_ip_operand1 + ix_ip_operand2;
      OP_SLL:  alu_raw = ix_ip_operand1 << shamt;
      OP_SLT:  alu_raw = {63'd0, $signed(ix_ip_operand1) < $signed(ix_ip_operand2)};
      OP_SLTU: alu_raw = {63'd0, ix_ip_operand1 < ix_ip_operand2};
      OP_XOR:  alu_raw = ix_ip_operand1 ^ ix_ip_operand2;
      OP_SRL:  alu_raw = ix_ip_option ? sra_res : ix_ip_operand1 >> shamt;
      OP_OR:   alu_raw = ix_ip_operand1 | ix_ip_operand2;
      OP_AND:  alu_raw = ix_ip_operand1 & ix_ip_operand2;
      default: alu_raw = '0;
    endcase
    alu_out = ix_ip_truncate ? {{32{alu_raw[31]}}, alu_raw[31:0]} : alu_raw;
  end

  // adv[k] is a running OR from the output end, so the chain lives in a local
  // variable rather than reading adv back into itself.
  always_comb begin
    logic chain;
    adv   = '0;
    chain = ip_ix_ready;
    for (int unsigned i = 0; i < STAGES; i++) begin
      chain = chain || !valid_q[STAGES-1-i];
      adv[STAGES-1-i] = chain;
    end
  end

  assign ix_ip_ready = adv[0] && !ip_flush;

  always_comb begin
    valid_nxt = valid_q;
    if (ip_flush) begin
      valid_nxt = '0;
    end else begin
      if (adv[0]) valid_nxt[0] = ix_ip_valid;
      for (int unsigned i = 1; i < STAGES; i++) begin
        if (adv[i]) valid_nxt[i] = valid_q[i-1];
      end
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      cnt_nxt = cnt_nxt + CNT_W'(valid_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      wb_q    <= '0;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        dst_q[i] <= '0;
        res_q[i] <= '0;
        pc_q[i]  <= '0;
      end
    end else begin
      valid_q <= valid_nxt;
      cnt_q   <= cnt_nxt;
      // Flush only clears valids; data registers keep whatever they held.
      if (!ip_flush) begin
        if (adv[0]) begin
          dst_q[0] <= ix_ip_dst;
          res_q[0] <= alu_out;
          pc_q[0]  <= ix_ip_pc;
          wb_q[0]  <= ix_ip_wb_en;
        end
        for (int unsigned i = 1; i < STAGES; i++) begin
          if (adv[i]) begin
            dst_q[i] <= dst_q[i-1];
            res_q[i] <= res_q[i-1];
            pc_q[i]  <= pc_q[i-1];
            wb_q[i]  <= wb_q[i-1];
          end
        end
      end
    end
  end

  assign ip_ix_valid  = valid_q[STAGES-1];
  assign ip_ix_dst    = dst_q[STAGES-1];
  assign ip_ix_result = res_q[STAGES-1];
  assign ip_ix_pc     = pc_q[STAGES-1];
  assign ip_ix_wb_en  = wb_q[STAGES-1];
  assign ip_inflight  = cnt_q;
  assign ip_busy      = (cnt_q != '0);

endmodule
